// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: execute-stage request/response bundle for the multiply/divide engine.
// Latency: none, wires only.
// Backpressure: the engine reports Busy/Stall; the master must hold the pipeline while set.
interface mul_div_unit_if;
  logic        Start;
  logic [3:0]  ALUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic        Stall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Result;

  modport master (
    output Start, ALUOp, A, B,
    input  Busy, Done, Stall, HI, LO, Result
  );

  modport slave (
    input  Start, ALUOp, A, B,
    output Busy, Done, Stall, HI, LO, Result
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed multiply / restoring divide with architectural HI/LO.
// Latency: Busy for 32 cycles after the start edge; HI/LO written and Done pulsed on the 32nd.
// Backpressure: Busy/Stall hold the pipeline; a Start seen while busy is dropped, not queued.
module mul_div_unit (
  input  logic          clock,
  input  logic          reset,
  mul_div_unit_if.slave bus
);

  // ALU control encodings (ALU_Parameters.vh)
  localparam logic [3:0] AluOp_Mul  = 4'd10;
  localparam logic [3:0] AluOp_Div  = 4'd11;
  localparam logic [3:0] AluOp_Mfhi = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        sign_a;
  logic        sign_b;
  logic        div_zero;
  logic        busy;
  logic        done;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] hi;
  logic [31:0] lo;
  // MUL: {partial product high, remaining multiplier bits}
  // DIV: {partial remainder, dividend bits shifting out / quotient bits shifting in}
  logic [63:0] acc;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        start_ok;
  logic [32:0] mul_sum;
  logic [63:0] mul_nx;
  logic [63:0] prod;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic        div_ge;
  logic [63:0] div_nx;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] a_orig;
  logic        unused_bits;

  // Operand magnitudes captured at start; 0x80000000 maps to itself as unsigned.
  always_comb begin
    abs_a    = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
    abs_b    = bus.B[31] ? (~bus.B + 32'd1) : bus.B;
    start_ok = bus.Start && ((bus.ALUOp == AluOp_Mul) || (bus.ALUOp == AluOp_Div));
  end

  // One shift-add multiply step plus the sign-corrected final product.
  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
    mul_nx  = {mul_sum, acc[31:1]};
    prod    = (sign_a ^ sign_b) ? (~mul_nx + 64'd1) : mul_nx;
  end

  // One restoring divide step plus sign-corrected quotient/remainder.
  always_comb begin
    div_shift = {acc[63:32], acc[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
    div_ge    = ~div_diff[33];
    div_nx    = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc[30:0], div_ge};
    quo_s     = (sign_a ^ sign_b) ? (~div_nx[31:0] + 32'd1) : div_nx[31:0];
    rem_s     = sign_a ? (~div_nx[63:32] + 32'd1) : div_nx[63:32];
    a_orig    = sign_a ? (~mag_a + 32'd1) : mag_a;
  end

  // A successful trial subtraction is always below the divisor, so bit 32 is zero.
  assign unused_bits = div_diff[32];

  // Control FSM and datapath registers; HI/LO move only on completion or reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      mag_a    <= 32'd0;
      mag_b    <= 32'd0;
      acc      <= 64'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state    <= (bus.ALUOp == AluOp_Mul) ? MUL : DIV;
            busy     <= 1'b1;
            cnt      <= 5'd31;
            sign_a   <= bus.A[31];
            sign_b   <= bus.B[31];
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            div_zero <= (bus.B == 32'd0);
            acc      <= {32'd0, (bus.ALUOp == AluOp_Mul) ? abs_b : abs_a};
          end
        end
        MUL: begin
          acc <= mul_nx;
          if (cnt == 5'd0) begin
            hi    <= prod[63:32];
            lo    <= prod[31:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DIV: begin
          acc <= div_nx;
          if (cnt == 5'd0) begin
            // Divide by zero still runs the full latency, then returns HI = A, LO = all ones.
            hi    <= div_zero ? a_orig : rem_s;
            lo    <= div_zero ? 32'hFFFF_FFFF : quo_s;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy   = busy;
  assign bus.Done   = done;
  assign bus.HI     = hi;
  assign bus.LO     = lo;
  assign bus.Stall  = busy | ((bus.ALUOp == AluOp_Mfhi) & busy);
  assign bus.Result = (bus.ALUOp == AluOp_Mfhi) ? hi : 32'd0;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized and directed scoreboard bench for mul_div_unit.
// Latency: expects Done 32 cycles after each accepted start with Busy high for those 32.
// Backpressure: stimulus waits for Busy low before each issue, giving back-to-back starts.
module tb_mul_div_unit;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_DIV  = 4'd11;
  localparam logic [3:0] ALU_MFHI = 4'd12;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          t;
  } exp_t;

  logic        clk;
  logic        rst;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          busy_cnt = 0;
  logic [31:0] committed_hi = 32'd0;
  exp_t        exp_q[$];

  mul_div_unit_if bus();

  mul_div_unit dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic, truncating division.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.t = 0;
    if (op == ALU_MUL) begin
      p = sa * sb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
    end else begin
      q = sa / sb;
      r = sa % sb;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  function automatic logic [31:0] pick();
    int k;
    k = $urandom_range(0, 7);
    case (k)
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(1, 50));
      5:       return 32'(0 - $urandom_range(1, 50));
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard monitor: pops one expectation per Done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt     = 0;
      committed_hi = 32'd0;
      exp_q.delete();
    end else begin
      if (bus.Busy) busy_cnt++;
      if (bus.Done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got Done=1, expected no pending op");
        end else begin
          e = exp_q.pop_front();
          check("hi", bus.HI, e.hi);
          check("lo", bus.LO, e.lo);
          check("latency", 32'(cyc - e.t), 32'd32);
          check("busy_cycles", 32'(busy_cnt), 32'd32);
          committed_hi = e.hi;
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && bus.Busy; i++) @(negedge clk);
    if (bus.Busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got Busy=1, expected 0 within 100 cycles");
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !bus.Done; i++) @(negedge clk);
    check("done_seen", {31'd0, bus.Done}, 32'd1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output exp_t e);
    wait_idle();
    bus.Start = 1'b1;
    bus.ALUOp = op;
    bus.A     = a;
    bus.B     = b;
    e   = model(op, a, b);
    e.t = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    // Scramble inputs: only the latched copies may matter from here on.
    bus.Start = 1'b0;
    bus.ALUOp = 4'($urandom_range(0, 9));
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  initial begin
    exp_t        e;
    logic [31:0] stale;
    rst       = 1'b1;
    bus.Start = 1'b0;
    bus.ALUOp = ALU_MFHI;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    #1;
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_done", {31'd0, bus.Done}, 32'd0);
    check("rst_stall", {31'd0, bus.Stall}, 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    check("rst_result", bus.Result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed operations, issued back-to-back
    issue(ALU_MUL, 32'd7, 32'hFFFF_FFFD, e);
    issue(ALU_MUL, 32'h8000_0000, 32'h8000_0000, e);
    issue(ALU_MUL, 32'h7FFF_FFFF, 32'd2, e);
    issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2, e);
    issue(ALU_DIV, 32'd7, 32'hFFFF_FFFE, e);
    issue(ALU_DIV, 32'd5, 32'd0, e);
    issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, e);

    // Mfhi while busy shows stale HI with Stall; after Done shows the new HI
    wait_idle();
    @(negedge clk);
    stale = committed_hi;
    issue(ALU_MUL, 32'd123456, 32'hFFFF_0000, e);
    bus.ALUOp = ALU_MFHI;
    #1;
    check("mfhi_busy_stall", {31'd0, bus.Stall}, 32'd1);
    check("mfhi_busy_result", bus.Result, stale);
    @(negedge clk);
    wait_done();
    check("mfhi_done_stall", {31'd0, bus.Stall}, 32'd0);
    check("mfhi_done_result", bus.Result, e.hi);

    // Start while busy is dropped
    issue(ALU_DIV, 32'd1000, 32'd7, e);
    repeat (5) @(negedge clk);
    bus.Start = 1'b1;
    bus.ALUOp = ALU_DIV;
    bus.A     = 32'd99;
    bus.B     = 32'd0;
    @(negedge clk);
    bus.Start = 1'b0;
    check("busy_start_busy", {31'd0, bus.Busy}, 32'd1);

    // Start with a non-mul/div op does nothing
    wait_idle();
    bus.Start = 1'b1;
    bus.ALUOp = ALU_ADD;
    @(negedge clk);
    bus.Start = 1'b0;
    check("add_busy", {31'd0, bus.Busy}, 32'd0);
    @(negedge clk);
    check("add_busy2", {31'd0, bus.Busy}, 32'd0);
    check("add_done", {31'd0, bus.Done}, 32'd0);

    // Asynchronous reset mid-multiply
    issue(ALU_MUL, 32'd1234567, 32'hFFFF_FFF0, e);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, bus.Busy}, 32'd0);
    check("arst_done", {31'd0, bus.Done}, 32'd0);
    check("arst_hi", bus.HI, 32'd0);
    check("arst_lo", bus.LO, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(ALU_DIV, 32'hFFFF_FF9C, 32'd7, e);

    // Randomized operations
    for (int n = 0; n < 30; n++) begin
      issue(($urandom_range(0, 1) == 0) ? ALU_MUL : ALU_DIV, pick(), pick(), e);
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
